// File: rtl/src_coord_pkg.sv
// Shared definitions for the source-coordinate generator of the bicubic resizer.
// Holds the FSM encoding and the default geometry and fraction widths.
package src_coord_pkg;

  localparam int IMG_DIM_DEF = 100;
  localparam int FRAC_W_DEF  = 8;
  localparam int DIV_CYCLES  = FRAC_W_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_OUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/src_coord_gen_if.sv
// Request/response bundle between the resize controller and the coordinate generator.
// The generator sits on the slave side; the controller/consumer is the master.
interface src_coord_gen_if;
  import src_coord_pkg::*;

  logic                  start;
  logic [6:0]            base;
  logic [4:0]            SN;
  logic [5:0]            TN;
  logic                  out_ready;
  logic                  out_valid;
  logic [5:0]            out_idx;
  logic [6:0]            out_coord;
  logic [FRAC_W_DEF-1:0] out_frac;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  start, base, SN, TN, out_ready,
    output out_valid, out_idx, out_coord, out_frac, out_last, busy, done, err
  );

  modport master (
    output start, base, SN, TN, out_ready,
    input  out_valid, out_idx, out_coord, out_frac, out_last, busy, done, err
  );

endinterface

// File: rtl/frac_div.sv
// Sequential restoring divider producing round-half-up(r * 2^FRAC_W / d).
// One quotient bit per cycle; requires r < d so the quotient fits FRAC_W+1 bits.
module frac_div
  import src_coord_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic [5:0]        r_i,
  input  logic [5:0]        d_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              done_o
);

  localparam int STEPS = FRAC_W + 1;
  localparam int CW    = $clog2(STEPS + 1);

  logic [5:0]       rem_q;
  logic [5:0]       div_q;
  logic [STEPS-1:0] quo_q;
  logic [CW-1:0]    cnt_q;

  logic [6:0] rem_sh;
  logic       ge;
  logic [5:0] rem_nx;

  always_comb begin
    rem_sh = {rem_q, 1'b0};
    ge     = (rem_sh >= {1'b0, div_q});
    rem_nx = ge ? 6'(rem_sh - {1'b0, div_q}) : rem_sh[5:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= r_i;
      div_q <= d_i;
      quo_q <= '0;
      cnt_q <= CW'(STEPS);
    end else if (cnt_q != '0) begin
      rem_q <= rem_nx;
      quo_q <= {quo_q[STEPS-2:0], ge};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Halving with the dropped LSB added back gives round-half-up.
  assign frac_o = quo_q[STEPS-1:1] + {{(FRAC_W-1){1'b0}}, quo_q[0]};
  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/src_coord_gen.sv
// Streams source positions base + i*(SN-1)/(TN-1) as integer coordinate plus
// rounded fraction, one per handshake, for target indices 0..TN-1.
module src_coord_gen
  import src_coord_pkg::*;
#(
  parameter int IMG_DIM = IMG_DIM_DEF,
  parameter int FRAC_W  = FRAC_W_DEF
) (
  input logic            CLK,
  input logic            RST,
  src_coord_gen_if.slave sif
);

  state_t     state_q, state_d;
  logic [6:0] base_q, base_d;
  logic [5:0] d_q, d_d;
  logic [5:0] s_q, s_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] q_q, q_d;
  logic [5:0] r_q, r_d;
  logic       err_q, err_d;

  logic              div_start;
  logic [5:0]        div_r;
  logic [5:0]        div_d;
  logic [FRAC_W-1:0] div_frac;
  logic              div_done;

  logic [7:0] span_end;
  logic       bad_params;
  logic [6:0] step_sum;
  logic       out_valid;

  always_comb begin
    span_end   = {1'b0, sif.base} + {3'b000, sif.SN} - 8'd1;
    bad_params = (sif.SN < 5'd2) || (sif.TN < 6'd2) ||
                 ({1'b0, sif.SN} > sif.TN) || (span_end > 8'(IMG_DIM - 1));
    step_sum   = {1'b0, r_q} + {1'b0, s_q};
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    d_d       = d_q;
    s_d       = s_q;
    idx_d     = idx_q;
    q_d       = q_q;
    r_d       = r_q;
    err_d     = err_q;
    div_start = 1'b0;
    div_r     = r_q;
    div_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (sif.start) begin
          base_d = sif.base;
          d_d    = sif.TN - 6'd1;
          s_d    = {1'b0, sif.SN} - 6'd1;
          idx_d  = '0;
          q_d    = '0;
          r_d    = '0;
          if (bad_params) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            state_d   = ST_DIV;
            div_start = 1'b1;
            div_r     = '0;
            div_d     = sif.TN - 6'd1;
          end
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (sif.out_ready) begin
          if (idx_q == d_q) begin
            state_d = ST_DONE;
          end else begin
            // S <= D, so the remainder wraps at most once per step.
            idx_d = idx_q + 6'd1;
            if (step_sum >= {1'b0, d_q}) begin
              r_d = 6'(step_sum - {1'b0, d_q});
              q_d = q_q + 6'd1;
            end else begin
              r_d = step_sum[5:0];
            end
            div_start = 1'b1;
            div_r     = r_d;
            state_d   = ST_DIV;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      d_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      d_q     <= d_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  frac_div #(.FRAC_W(FRAC_W)) u_div (
    .CLK     (CLK),
    .RST     (RST),
    .start_i (div_start),
    .r_i     (div_r),
    .d_i     (div_d),
    .frac_o  (div_frac),
    .done_o  (div_done)
  );

  assign out_valid     = (state_q == ST_OUT);
  assign sif.out_valid = out_valid;
  assign sif.out_idx   = out_valid ? idx_q : '0;
  assign sif.out_coord = out_valid ? (base_q + {1'b0, q_q}) : '0;
  assign sif.out_frac  = out_valid ? div_frac : '0;
  assign sif.out_last  = out_valid && (idx_q == d_q);
  assign sif.busy      = (state_q == ST_DIV) || (state_q == ST_OUT);
  assign sif.done      = (state_q == ST_DONE);
  assign sif.err       = err_q;

endmodule

// File: tb/tb_src_coord_gen.sv
// Scoreboard bench for src_coord_gen: a position model fills a queue at each
// start and a negedge monitor checks every handshake, latency, stalls and done.
module tb_src_coord_gen;
  import src_coord_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  src_coord_gen_if sif();

  src_coord_gen #(.IMG_DIM(IMG_DIM_DEF), .FRAC_W(FRAC_W_DEF)) dut (
    .CLK (CLK),
    .RST (RST),
    .sif (sif)
  );

  typedef struct {
    int idx;
    int coord;
    int frac;
    bit last;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   ncmp = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   ref_cyc = -1;
  int   done_cyc = -1;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  bit   prev_valid = 0;
  bit   prev_stall = 0;
  int   prev_idx, prev_coord, prev_frac;
  bit   prev_last;

  always @(posedge CLK) cyc <= cyc + 1;

  // Consumer: always ready, random, or stalled.
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       sif.out_ready = 1'b1;
      1:       sif.out_ready = 1'($urandom_range(0, 1));
      default: sif.out_ready = 1'b0;
    endcase
  end

  always @(negedge CLK) begin
    if (RST) begin
      prev_valid = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        ncmp++;
        if (!(sif.out_valid && int'(sif.out_idx) == prev_idx && int'(sif.out_coord) == prev_coord &&
              int'(sif.out_frac) == prev_frac && sif.out_last == prev_last)) begin
          nerr++;
          $display("FAIL stall_hold: got v=%0b idx=%0d coord=%0d frac=%0d, need v=1 idx=%0d coord=%0d frac=%0d",
                   sif.out_valid, sif.out_idx, sif.out_coord, sif.out_frac, prev_idx, prev_coord, prev_frac);
        end
      end
      if (sif.out_valid && !prev_valid && ref_cyc >= 0) begin
        ncmp++;
        if (cyc - ref_cyc != 10) begin
          nerr++;
          $display("FAIL latency: got %0d cycles, need 10", cyc - ref_cyc);
        end
      end
      if (cyc == done_cyc) begin
        ncmp++;
        if (sif.done !== 1'b1) begin
          nerr++;
          $display("FAIL done_pulse: got done=%0b, need 1", sif.done);
        end
      end else if (sif.done) begin
        ncmp++;
        nerr++;
        $display("FAIL done_spurious: got done=1 at cycle %0d, need 0", cyc);
      end
      if (sif.done) done_cnt++;
      if (sif.out_valid && sif.out_ready) begin
        hs_cnt++;
        ref_cyc = cyc;
        ncmp++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL point_unexpected: got idx=%0d coord=%0d, need no point", sif.out_idx, sif.out_coord);
        end else begin
          e = sb.pop_front();
          $display("point idx=%0d coord=%0d frac=%0d last=%0b", sif.out_idx, sif.out_coord, sif.out_frac, sif.out_last);
          if (int'(sif.out_idx) != e.idx || int'(sif.out_coord) != e.coord ||
              int'(sif.out_frac) != e.frac || sif.out_last != e.last) begin
            nerr++;
            $display("FAIL point: got idx=%0d coord=%0d frac=%0d last=%0b, need idx=%0d coord=%0d frac=%0d last=%0b",
                     sif.out_idx, sif.out_coord, sif.out_frac, sif.out_last, e.idx, e.coord, e.frac, e.last);
          end
          if (e.last) done_cyc = cyc + 1;
        end
      end
      prev_valid = sif.out_valid;
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_idx   = int'(sif.out_idx);
      prev_coord = int'(sif.out_coord);
      prev_frac  = int'(sif.out_frac);
      prev_last  = sif.out_last;
    end
  end

  // Reference: position i maps to i*(SN-1)/(TN-1), fraction rounded half-up.
  task automatic push_model(input int b, input int sn, input int tn);
    int   d;
    int   num;
    exp_t x;
    d = tn - 1;
    for (int i = 0; i < tn; i++) begin
      num     = i * (sn - 1);
      x.idx   = i;
      x.coord = b + num / d;
      x.frac  = ((num % d) * 512 / d + 1) / 2;
      x.last  = (i == tn - 1);
      sb.push_back(x);
    end
  endtask

  task automatic pulse_start(input int b, input int sn, input int tn, output int sc);
    @(posedge CLK);
    #2;
    sif.base  = 7'(b);
    sif.SN    = 5'(sn);
    sif.TN    = 6'(tn);
    sif.start = 1'b1;
    sc        = cyc;
    @(posedge CLK);
    #2;
    sif.start = 1'b0;
  endtask

  task automatic start_seq(input int b, input int sn, input int tn);
    int sc;
    push_model(b, sn, tn);
    pulse_start(b, sn, tn, sc);
    ref_cyc = sc;
    ncmp++;
    if (sif.busy !== 1'b1 || sif.err !== 1'b0) begin
      nerr++;
      $display("FAIL start_accept: got busy=%0b err=%0b, need busy=1 err=0", sif.busy, sif.err);
    end
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(posedge CLK);
      k++;
    end
    ncmp++;
    if (done_cnt == d0) begin
      nerr++;
      $display("FAIL timeout_%s: got no done within 3000 cycles, need done", tag);
    end
    @(posedge CLK);
    #2;
    ncmp++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drained_%s: got %0d points pending, need 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic wait_hs(input int n);
    int k;
    k = 0;
    while (hs_cnt < n && k < 1000) begin
      @(posedge CLK);
      #2;
      k++;
    end
    if (hs_cnt < n) begin
      ncmp++;
      nerr++;
      $display("FAIL wait_handshake: got %0d handshakes, need %0d", hs_cnt, n);
    end
  endtask

  task automatic err_case(input int b, input int sn, input int tn);
    int sc;
    bit seen;
    pulse_start(b, sn, tn, sc);
    ncmp++;
    if (sif.err !== 1'b1 || sif.busy !== 1'b0) begin
      nerr++;
      $display("FAIL param_err b=%0d sn=%0d tn=%0d: got err=%0b busy=%0b, need err=1 busy=0",
               b, sn, tn, sif.err, sif.busy);
    end else begin
      $display("param error b=%0d sn=%0d tn=%0d flagged", b, sn, tn);
    end
    seen = 0;
    repeat (12) begin
      @(posedge CLK);
      #2;
      if (sif.out_valid) seen = 1;
    end
    ncmp++;
    if (seen) begin
      nerr++;
      $display("FAIL err_no_valid: got out_valid=1, need 0");
    end
  endtask

  task automatic check_zero(input string tag);
    ncmp++;
    if (sif.out_valid !== 1'b0 || sif.out_idx !== '0 || sif.out_coord !== '0 || sif.out_frac !== '0 ||
        sif.out_last !== 1'b0 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.err !== 1'b0) begin
      nerr++;
      $display("FAIL %s: got v=%0b idx=%0d coord=%0d frac=%0d last=%0b busy=%0b done=%0b err=%0b, need all 0",
               tag, sif.out_valid, sif.out_idx, sif.out_coord, sif.out_frac, sif.out_last,
               sif.busy, sif.done, sif.err);
    end
  endtask

  initial begin
    int tn, sn, b;
    sif.start     = 1'b0;
    sif.base      = '0;
    sif.SN        = '0;
    sif.TN        = '0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check_zero("reset_state");
    RST = 1'b0;

    ready_mode = 0;
    start_seq(81, 17, 22);
    wait_done("h_case");
    start_seq(18, 15, 28);
    wait_done("v_case");

    // Stall five cycles on i=2.
    hs_cnt = 0;
    start_seq(81, 17, 22);
    wait_hs(2);
    ready_mode = 2;
    for (int k = 0; k < 40 && !sif.out_valid; k++) begin
      @(posedge CLK);
      #2;
    end
    repeat (4) @(posedge CLK);
    #2;
    ready_mode = 0;
    wait_done("stall");

    err_case(50, 20, 10);
    err_case(90, 17, 22);
    err_case(10, 1, 22);

    // Reset in the middle of the i=5 division.
    hs_cnt = 0;
    start_seq(81, 17, 22);
    wait_hs(5);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_zero("mid_reset");
    sb.delete();
    done_cyc = -1;
    RST = 1'b0;
    start_seq(81, 17, 22);
    wait_done("after_reset");

    // A second start mid-run must be ignored.
    hs_cnt = 0;
    start_seq(81, 17, 22);
    wait_hs(3);
    begin
      int sc;
      pulse_start(10, 5, 9, sc);
    end
    ncmp++;
    if (sif.busy !== 1'b1 || sif.err !== 1'b0) begin
      nerr++;
      $display("FAIL start_ignored: got busy=%0b err=%0b, need busy=1 err=0", sif.busy, sif.err);
    end
    wait_done("restart_ignored");

    ready_mode = 1;
    repeat (6) begin
      tn = int'($urandom_range(2, 40));
      sn = int'($urandom_range(2, (tn < 31) ? tn : 31));
      b  = int'($urandom_range(0, IMG_DIM_DEF - sn));
      start_seq(b, sn, tn);
      wait_done("random");
    end
    repeat (3) begin
      sn = int'($urandom_range(2, 31));
      tn = int'($urandom_range(sn, 63));
      b  = int'($urandom_range(IMG_DIM_DEF + 1 - sn, 127));
      err_case(b, sn, tn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
